// File: rtl/cic_decim_pkg.sv
// Shared types and constants for the CIC decimator: internal width helper,
// accumulator type at default sizing and the comb sequencer state encoding.
package cic_decim_pkg;

    localparam int DEF_IN_BITS  = 9;
    localparam int DEF_DEC_LOG2 = 6;
    localparam int DEF_N_STAGES = 4;
    localparam int DEF_OUT_BITS = 16;

    // Bit growth of an N-stage CIC with ratio R is N*log2(R).
    function automatic int cic_width(input int in_bits, input int n_stages, input int dec_log2);
        return in_bits + n_stages * dec_log2;
    endfunction

    localparam int DEF_W = cic_width(DEF_IN_BITS, DEF_N_STAGES, DEF_DEC_LOG2);

    typedef logic signed [DEF_W-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMB,
        ST_OUT,
        ST_DONE
    } cic_state_e;

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: W-bit wrapping accumulator, advanced only on enable.
module cic_integrator
    import cic_decim_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic                CLK_24M,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] acc
);

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_decimator_3m.sv
// Decimating CIC: integrators at the 3 MHz sample rate, comb chain time-shared on one
// subtractor at CLK_24M. Define CIC_ROUND_EN for round-half-up with output saturation.
module cic_decimator_3m
    import cic_decim_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int DEC_LOG2 = DEF_DEC_LOG2,
    parameter int N_STAGES = DEF_N_STAGES,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                       CLK_24M,
    input  logic                       reset,
    input  logic                       enable_sampling_3M,
    input  logic signed [IN_BITS-1:0]  sample_in,
    output logic signed [OUT_BITS-1:0] pcm_out,
    output logic                       pcm_valid,
    output logic                       overrun
);

    localparam int W     = cic_width(IN_BITS, N_STAGES, DEC_LOG2);
    localparam int SHIFT = W - OUT_BITS;
    localparam int IDXW  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    logic signed [W-1:0]        integ     [N_STAGES];
    logic signed [W-1:0]        integ_din [N_STAGES];
    logic signed [W-1:0]        comb_d    [N_STAGES];
    logic [DEC_LOG2-1:0]        dec_cnt;
    logic signed [W-1:0]        snapshot;
    logic signed [W-1:0]        comb_y;
    logic signed [W-1:0]        comb_prev;
    logic signed [W-1:0]        comb_sub;
    logic signed [OUT_BITS-1:0] scaled;
    logic [IDXW-1:0]            comb_idx;
    cic_state_e                 state;
    logic                       dec_event;

    genvar gi;

    // Pipelined cascade: each stage accumulates the registered output of the previous one.
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_int
            if (gi == 0) begin : g_first
                assign integ_din[gi] = {{(W-IN_BITS){sample_in[IN_BITS-1]}}, sample_in};
            end else begin : g_rest
                assign integ_din[gi] = integ[gi-1];
            end
            cic_integrator #(.W(W)) u_integ (
                .CLK_24M (CLK_24M),
                .reset   (reset),
                .en      (enable_sampling_3M),
                .din     (integ_din[gi]),
                .acc     (integ[gi])
            );
        end
    endgenerate

    assign dec_event = enable_sampling_3M && (dec_cnt == '1);

    // Shared comb subtractor: stage k differences the previous stage's result with its delay.
    assign comb_prev = (comb_idx == '0) ? snapshot : comb_y;
    assign comb_sub  = comb_prev - comb_d[comb_idx];

    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_comb
            logic signed [W-1:0] d_reg;
            always_ff @(posedge CLK_24M or negedge reset) begin
                if (!reset) begin
                    d_reg <= '0;
                end else if (state == ST_COMB && comb_idx == IDXW'(gi)) begin
                    d_reg <= comb_prev;
                end
            end
            assign comb_d[gi] = d_reg;
        end
    endgenerate

`ifdef CIC_ROUND_EN
    localparam logic [W:0] HALF = {{W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [OUT_BITS-1:0] PCM_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [OUT_BITS-1:0] PCM_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    logic signed [W:0]       rounded;
    logic signed [W-SHIFT:0] shifted;
    logic                    fits;

    assign rounded = $signed({comb_y[W-1], comb_y} + HALF);
    assign shifted = rounded[W:SHIFT];
    assign fits    = (&shifted[W-SHIFT:OUT_BITS-1]) || !(|shifted[W-SHIFT:OUT_BITS-1]);
    assign scaled  = fits ? shifted[OUT_BITS-1:0] : (shifted[W-SHIFT] ? PCM_MIN : PCM_MAX);
`else
    assign scaled = comb_y[W-1:SHIFT];
`endif

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            dec_cnt   <= '0;
            snapshot  <= '0;
            comb_y    <= '0;
            comb_idx  <= '0;
            state     <= ST_IDLE;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (enable_sampling_3M) begin
                dec_cnt <= dec_cnt + 1'b1;
            end
            if (dec_event && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (dec_event) begin
                        snapshot <= integ[N_STAGES-1];
                        comb_idx <= '0;
                        state    <= ST_COMB;
                    end
                end
                ST_COMB: begin
                    comb_y <= comb_sub;
                    if (comb_idx == IDXW'(N_STAGES - 1)) begin
                        state <= ST_OUT;
                    end else begin
                        comb_idx <= comb_idx + 1'b1;
                    end
                end
                ST_OUT: begin
                    pcm_out   <= scaled;
                    pcm_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    pcm_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_decimator_3m.sv
// Self-checking bench for cic_decimator_3m: table of DC vectors, random samples against a
// behavioural CIC model via an expected-output queue, plus overrun and mid-computation reset.
`timescale 1ns/1ps
module tb_cic_decimator_3m;

    localparam int W  = 33;
    localparam int SH = 17;

    logic               CLK_24M = 1'b0;
    logic               reset;
    logic               en;
    logic signed [8:0]  sample;
    logic signed [15:0] pcm_out;
    logic               pcm_valid;
    logic               overrun;

    logic               en2;
    logic signed [8:0]  sample2;
    logic signed [15:0] pcm_out2;
    logic               pcm_valid2;
    logic               overrun2;

    always #5 CLK_24M = ~CLK_24M;

    cic_decimator_3m dut (
        .CLK_24M            (CLK_24M),
        .reset              (reset),
        .enable_sampling_3M (en),
        .sample_in          (sample),
        .pcm_out            (pcm_out),
        .pcm_valid          (pcm_valid),
        .overrun            (overrun)
    );

    // Short decimation ratio so back-to-back enables outpace the comb sequencer.
    cic_decimator_3m #(.DEC_LOG2(2)) dut_ovr (
        .CLK_24M            (CLK_24M),
        .reset              (reset),
        .enable_sampling_3M (en2),
        .sample_in          (sample2),
        .pcm_out            (pcm_out2),
        .pcm_valid          (pcm_valid2),
        .overrun            (overrun2)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic prev_valid = 1'b0;

    logic signed [15:0] exp_q[$];
    int                 cyc_q[$];

    logic signed [W-1:0] m_i [4];
    logic signed [W-1:0] m_d [4];
    int                  m_cnt;

    typedef struct {
        logic signed [8:0]  sample;
        int                 n_out;
        logic signed [15:0] exp_pcm;
    } vec_t;

    vec_t vecs [5];

    always @(posedge CLK_24M) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] scale(input logic signed [W-1:0] y);
        longint v;
`ifdef CIC_ROUND_EN
        v = (longint'(y) + 64'sd65536) >>> SH;
        if (v > 32767)  return 16'sh7fff;
        if (v < -32768) return 16'sh8000;
        return 16'(v);
`else
        v = longint'(y) >>> SH;
        return 16'(v);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_i[k] = '0;
            m_d[k] = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_sample(input logic signed [8:0] x, input int ev_cyc);
        logic signed [W-1:0] old [4];
        logic signed [W-1:0] yp;
        logic signed [W-1:0] y;
        for (int k = 0; k < 4; k++) old[k] = m_i[k];
        if (m_cnt == 63) begin
            yp = old[3];
            y  = '0;
            for (int k = 0; k < 4; k++) begin
                y      = yp - m_d[k];
                m_d[k] = yp;
                yp     = y;
            end
            exp_q.push_back(scale(y));
            cyc_q.push_back(ev_cyc);
        end
        m_i[0] = old[0] + W'(x);
        for (int k = 1; k < 4; k++) m_i[k] = old[k] + old[k-1];
        m_cnt = (m_cnt + 1) % 64;
    endtask

    task automatic drive_sample(input logic signed [8:0] x, input int post);
        @(negedge CLK_24M);
        en = 1'b1;
        sample = x;
        model_sample(x, cyc + 1);
        @(negedge CLK_24M);
        en = 1'b0;
        repeat (post) @(negedge CLK_24M);
    endtask

    task automatic run_const(input logic signed [8:0] x, input int n);
        for (int s = 0; s < n; s++) drive_sample(x, 6);
    endtask

    // Scoreboard side: every pcm_valid pops one expected sample and its event cycle.
    always @(negedge CLK_24M) begin
        if (pcm_valid) begin
            check("pulse_width", 64'(prev_valid), 64'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_pcm_valid: got pcm_out=%0d, expected no output (t=%0t)", pcm_out, $time);
            end else begin
                check("pcm_out", 64'(pcm_out), 64'(exp_q.pop_front()));
                check("latency", 64'(cyc - cyc_q.pop_front()), 64'd5);
            end
        end
        prev_valid <= pcm_valid;
    end

    initial begin
        vecs[0] = '{sample: 9'sd100,  n_out: 8, exp_pcm: 16'sd12800};
        vecs[1] = '{sample: -9'sd256, n_out: 8, exp_pcm: -16'sd32768};
        vecs[2] = '{sample: 9'sd255,  n_out: 8, exp_pcm: 16'sd32640};
        vecs[3] = '{sample: -9'sd1,   n_out: 8, exp_pcm: -16'sd128};
        vecs[4] = '{sample: 9'sd0,    n_out: 8, exp_pcm: 16'sd0};

        reset   = 1'b0;
        en      = 1'b0;
        sample  = '0;
        en2     = 1'b0;
        sample2 = 9'sd5;
        model_reset();

        for (int c = 0; c < 20; c++) begin
            @(negedge CLK_24M);
            en = ~en;
            sample = 9'sd77;
            check("reset_pcm_out", 64'(pcm_out), 64'd0);
            check("reset_pcm_valid", 64'(pcm_valid), 64'd0);
            check("reset_overrun", 64'(overrun), 64'd0);
        end
        @(negedge CLK_24M);
        en = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_const(vecs[i].sample, vecs[i].n_out * 64);
            check($sformatf("dc_settled[%0d]", i), 64'(pcm_out), 64'(vecs[i].exp_pcm));
        end

        for (int s = 0; s < 6 * 64; s++) begin
            logic signed [8:0] r;
            r = 9'($urandom_range(0, 511));
            drive_sample(r, 6);
        end

        check("overrun_idle", 64'(overrun2), 64'd0);
        @(negedge CLK_24M);
        en2 = 1'b1;
        repeat (40) @(negedge CLK_24M);
        check("overrun_set", 64'(overrun2), 64'd1);
        en2 = 1'b0;
        repeat (20) @(negedge CLK_24M);
        check("overrun_sticky", 64'(overrun2), 64'd1);

        run_const(9'sd50, 63);
        drive_sample(9'sd50, 2);
        reset = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        model_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK_24M);
            check("midreset_pcm_valid", 64'(pcm_valid), 64'd0);
            check("midreset_pcm_out", 64'(pcm_out), 64'd0);
            check("midreset_overrun2", 64'(overrun2), 64'd0);
        end
        reset = 1'b1;

        run_const(9'sd100, 8 * 64);
        check("post_reset_dc", 64'(pcm_out), 64'sd12800);
        check("no_overrun_main", 64'(overrun), 64'd0);
        repeat (8) @(negedge CLK_24M);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
